// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encoding and the default operand width.
package seq_divider_pkg;

  localparam int DEF_N = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/seq_divider_trial_sub.sv
// Combinational W-bit trial subtractor a - b, built as a ripple chain of
// full-adder cells adding the inverted subtrahend with carry-in 1.
// borrow is the inverted final carry: 1 means a < b.
module div_trial_sub #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic [W:0]   carry;
  logic [W-1:0] b_inv;

  assign carry[0] = 1'b1;
  assign b_inv    = ~b;

  // One full-adder cell per bit; carry ripples from LSB to MSB
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign diff[i]      = a[i] ^ b_inv[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b_inv[i]) | (a[i] & carry[i]) | (b_inv[i] & carry[i]);
  end

  assign borrow = ~carry[W];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one
// quotient bit per clock, start/done handshake. Divide by zero skips the
// iterations and reports an all-ones quotient with div_zero set.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           ready,
  output logic           done,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           div_zero
);

  localparam int CNT_W = $clog2(2 * N);

  div_state_t     state;
  logic [2*N-1:0] q_reg;
  logic [N:0]     r_reg;
  logic [N-1:0]   dvs_reg;
  logic [CNT_W-1:0] cnt;
  logic           dz_pend;

  logic [N:0]     trial_s;
  logic [N:0]     trial_d;
  logic [N:0]     trial_t;
  logic           trial_borrow;

  // Shift the next dividend bit into the partial remainder for this iteration
  always_comb begin
    trial_s = {r_reg[N-1:0], q_reg[2*N-1]};
    trial_d = {1'b0, dvs_reg};
  end

  div_trial_sub #(
    .W (N + 1)
  ) u_trial (
    .a      (trial_s),
    .b      (trial_d),
    .diff   (trial_t),
    .borrow (trial_borrow)
  );

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ready     <= 1'b1;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      q_reg     <= '0;
      r_reg     <= '0;
      dvs_reg   <= '0;
      cnt       <= '0;
      dz_pend   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ready    <= 1'b0;
            div_zero <= 1'b0;
            if (divisor != '0) begin
              dvs_reg <= divisor;
              q_reg   <= dividend;
              r_reg   <= '0;
              cnt     <= CNT_W'(2 * N - 1);
              dz_pend <= 1'b0;
              state   <= RUN;
            end else begin
              // No iterations needed; the result is fixed
              dz_pend <= 1'b1;
              state   <= DONE;
            end
          end
        end
        RUN: begin
          // Keep the difference when it did not borrow, otherwise restore
          r_reg <= trial_borrow ? trial_s : trial_t;
          q_reg <= {q_reg[2*N-2:0], ~trial_borrow};
          cnt   <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          ready <= 1'b1;
          state <= IDLE;
          if (dz_pend) begin
            quotient  <= '1;
            remainder <= '0;
            div_zero  <= 1'b1;
          end else begin
            quotient  <= q_reg;
            remainder <= r_reg[N-1:0];
            div_zero  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: stimulus pushes expected results into a
// scoreboard queue, a negedge monitor pops and compares on done and
// also tracks ready and output hold between operations.
module tb_seq_divider;

  localparam int N  = 4;
  localparam int W2 = 2 * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W2-1:0] dividend = '0;
  logic [N-1:0]  divisor = '0;
  logic          ready;
  logic          done;
  logic [W2-1:0] quotient;
  logic [N-1:0]  remainder;
  logic          div_zero;

  typedef struct {
    logic [W2-1:0] q;
    logic [N-1:0]  r;
    logic          dz;
    int            due;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [W2-1:0] last_q = '0;
  logic [N-1:0]  last_r = '0;
  logic          last_dz = 1'b0;

  seq_divider #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .ready     (ready),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare outputs against the scoreboard every falling edge
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("ready", 32'(ready), (sb.size() > 0 && cyc < sb[0].due) ? 32'd0 : 32'd1);
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("quotient", 32'(quotient), 32'(e.q));
          chk("remainder", 32'(remainder), 32'(e.r));
          chk("div_zero", 32'(div_zero), 32'(e.dz));
          chk("latency", cyc, e.due);
          last_q  = e.q;
          last_r  = e.r;
          last_dz = e.dz;
        end
      end else begin
        chk("hold_quotient", 32'(quotient), 32'(last_q));
        chk("hold_remainder", 32'(remainder), 32'(last_r));
        chk("hold_div_zero", 32'(div_zero), 32'(last_dz));
        if (sb.size() > 0 && cyc >= sb[0].due) begin
          checks++;
          errors++;
          $display("FAIL missing_done: got done=0 expected done=1 (cycle %0d)", cyc);
          void'(sb.pop_front());
        end
      end
    end
  end

  // Present one operation and wait for it to be accepted
  task automatic issue(input logic [W2-1:0] dvd, input logic [N-1:0] dvs);
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      if (ready) break;
      @(negedge clk); #1;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got ready=0 expected ready=1");
    end
    start    = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    @(posedge clk); #1;
    if (dvs == '0) begin
      e.q   = '1;
      e.r   = '0;
      e.dz  = 1'b1;
      e.due = cyc + 1;
    end else begin
      e.q   = W2'(int'(dvd) / int'(dvs));
      e.r   = N'(int'(dvd) % int'(dvs));
      e.dz  = 1'b0;
      e.due = cyc + W2 + 1;
    end
    sb.push_back(e);
    last_dz  = 1'b0;
    start    = 1'b0;
    dividend = W2'($urandom);
    divisor  = N'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk); #1;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got pending=%0d expected pending=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_op(input logic [W2-1:0] dvd, input logic [N-1:0] dvs);
    issue(dvd, dvs);
    wait_idle();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_quotient"}, 32'(quotient), 32'd0);
    chk({tag, "_remainder"}, 32'(remainder), 32'd0);
    chk({tag, "_div_zero"}, 32'(div_zero), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    #2 rst_n = 1'b1;
    @(negedge clk); #1;

    do_op(8'd143, 4'd13);
    do_op(8'd100, 4'd7);
    do_op(8'd7, 4'd9);
    do_op(8'd255, 4'd1);
    do_op(8'd200, 4'd0);
    do_op(8'd20, 4'd4);

    // start while busy must be ignored
    issue(8'd143, 4'd13);
    repeat (2) @(negedge clk);
    #1;
    start    = 1'b1;
    dividend = 8'd50;
    divisor  = 4'd5;
    @(negedge clk); #1;
    start = 1'b0;
    wait_idle();
    repeat (12) @(negedge clk);
    #1;

    // reset in the middle of an operation
    issue(8'd143, 4'd13);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    last_q  = '0;
    last_r  = '0;
    last_dz = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    do_op(8'd60, 4'd15);

    // X*Y / Y must give back X with zero remainder
    for (int x = 1; x < 16; x++) begin
      for (int y = 1; y < 16; y++) begin
        do_op(W2'(x * y), N'(y));
      end
    end

    // random operands, divisor zero included
    for (int k = 0; k < 200; k++) begin
      do_op(W2'($urandom_range(0, 255)), N'($urandom_range(0, 15)));
    end

    repeat (4) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
